// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings for the banked stack sequencer
package stack_pkg;
    typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_LOAD} op_e;
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BURST, S_RESP} state_e;
    localparam logic [2:0] FAULT_NONE      = 3'd0;
    localparam logic [2:0] FAULT_OVERFLOW  = 3'd1;
    localparam logic [2:0] FAULT_UNDERFLOW = 3'd2;
    localparam logic [2:0] FAULT_BAD_LOAD  = 3'd3;
    localparam logic [2:0] FAULT_BAD_COUNT = 3'd4;
    // Wide enough for any SP width; users slice the low DATA_WIDTH bits.
    localparam logic [63:0] EMPTY_SP = '1;
endpackage

// File: rtl/stack_bounds.sv
// stack_bounds: per-bank address window and occupancy of the selected bank
module stack_bounds
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BW          = 1,
    parameter int STACK_BASE  = 4096,
    parameter int STACK_DEPTH = 2048
) (
    input  logic [BW-1:0]         bank_i,
    input  logic [DATA_WIDTH-1:0] sp_i,
    output logic [DATA_WIDTH-1:0] top_o,
    output logic [DATA_WIDTH-1:0] bottom_o,
    output logic [DATA_WIDTH-1:0] items_o,
    output logic [DATA_WIDTH-1:0] free_o
);
    localparam logic [DATA_WIDTH-1:0] EMPTY = EMPTY_SP[DATA_WIDTH-1:0];

    assign top_o    = DATA_WIDTH'(STACK_BASE) + DATA_WIDTH'(bank_i) * DATA_WIDTH'(STACK_DEPTH);
    assign bottom_o = top_o + DATA_WIDTH'(STACK_DEPTH - 1);
    assign items_o  = (sp_i == EMPTY) ? '0 : bottom_o - sp_i + DATA_WIDTH'(1);
    assign free_o   = DATA_WIDTH'(STACK_DEPTH) - items_o;
endmodule

// File: rtl/banked_stack_sequencer.sv
// banked_stack_sequencer: per-bank stack pointers with validated push/pop burst address streaming
module banked_stack_sequencer
    import stack_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_BANKS   = 2,
    parameter int STACK_BASE  = 4096,
    parameter int STACK_DEPTH = 2048,
    parameter int MAX_BURST   = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [1:0]                       cmd_op_i,
    input  logic [$clog2(NUM_BANKS)-1:0]     cmd_bank_i,
    input  logic [$clog2(MAX_BURST+1)-1:0]   cmd_count_i,
    input  logic [DATA_WIDTH-1:0]            cmd_load_value_i,
    output logic                             mem_valid_o,
    input  logic                             mem_ready_i,
    output logic                             mem_write_o,
    output logic [ADDR_WIDTH-1:0]            mem_address_o,
    output logic [$clog2(MAX_BURST)-1:0]     beat_index_o,
    output logic                             done_o,
    output logic                             fault_o,
    output logic [2:0]                       fault_code_o,
    input  logic [$clog2(NUM_BANKS)-1:0]     sp_bank_i,
    output logic [DATA_WIDTH-1:0]            sp_value_o
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(MAX_BURST);
    localparam logic [DATA_WIDTH-1:0] EMPTY = EMPTY_SP[DATA_WIDTH-1:0];

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [BW-1:0]         bank_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] new_sp_q, new_sp_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [IW-1:0]         beat_q;
    logic [2:0]            code_q, code_d;
    logic [DATA_WIDTH-1:0] sp_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] cur_sp, top, bottom, items, free, cnt, push_start;
    logic                  is_push, is_pop, in_burst, last_beat;

    assign cur_sp     = sp_q[bank_q];
    assign is_push    = op_q == OP_PUSH;
    assign is_pop     = op_q == OP_POP;
    assign in_burst   = state_q == S_BURST;
    assign last_beat  = CW'(beat_q) == count_q - CW'(1);
    assign sp_value_o = sp_q[sp_bank_i];

    stack_bounds #(
        .DATA_WIDTH (DATA_WIDTH),
        .BW         (BW),
        .STACK_BASE (STACK_BASE),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_bounds (
        .bank_i  (bank_q),
        .sp_i    (cur_sp),
        .top_o   (top),
        .bottom_o(bottom),
        .items_o (items),
        .free_o  (free)
    );

    // Validate the latched command and precompute burst start and final SP.
    always_comb begin
        cnt        = DATA_WIDTH'(count_q);
        push_start = (cur_sp == EMPTY) ? bottom : cur_sp - DATA_WIDTH'(1);
        code_d     = ((is_push || is_pop) && (count_q == '0 || count_q > CW'(MAX_BURST))) ? FAULT_BAD_COUNT :
                     (is_push && cnt > free)  ? FAULT_OVERFLOW :
                     (is_pop && cnt > items)  ? FAULT_UNDERFLOW :
                     (op_q == OP_LOAD && value_q != EMPTY && (value_q < top || value_q > bottom)) ? FAULT_BAD_LOAD :
                     FAULT_NONE;
        start_d    = is_push ? push_start[ADDR_WIDTH-1:0] : cur_sp[ADDR_WIDTH-1:0];
        new_sp_d   = is_push ? push_start - (cnt - DATA_WIDTH'(1)) :
                     is_pop  ? ((cur_sp + cnt > bottom) ? EMPTY : cur_sp + cnt) :
                     (op_q == OP_LOAD) ? value_q : cur_sp;
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = cmd_valid_i ? S_CHECK : S_IDLE;
            S_CHECK: state_d = (code_d == FAULT_NONE && (is_push || is_pop)) ? S_BURST : S_RESP;
            S_BURST: state_d = (mem_ready_i && last_beat) ? S_RESP : S_BURST;
            default: state_d = S_IDLE;
        endcase
        cmd_ready_o   = state_q == S_IDLE;
        mem_valid_o   = in_burst;
        mem_write_o   = in_burst && is_push;
        mem_address_o = !in_burst ? '0 : is_push ? start_q - ADDR_WIDTH'(beat_q) : start_q + ADDR_WIDTH'(beat_q);
        beat_index_o  = in_burst ? beat_q : '0;
        done_o        = state_q == S_RESP;
        fault_o       = done_o && code_q != FAULT_NONE;
        fault_code_o  = done_o ? code_q : FAULT_NONE;
    end

    // Command latch, check results and beat counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            bank_q   <= '0;
            count_q  <= '0;
            value_q  <= '0;
            start_q  <= '0;
            new_sp_q <= '0;
            beat_q   <= '0;
            code_q   <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid_i) begin
                op_q    <= op_e'(cmd_op_i);
                bank_q  <= cmd_bank_i;
                count_q <= cmd_count_i;
                value_q <= cmd_load_value_i;
            end
            if (state_q == S_CHECK) begin
                code_q   <= code_d;
                start_q  <= start_d;
                new_sp_q <= new_sp_d;
                beat_q   <= '0;
            end
            if (in_burst && mem_ready_i) beat_q <= beat_q + IW'(1);
        end
    end

    // Stack pointers commit only in RESP, so a burst never leaves a partial update.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < NUM_BANKS; b++) sp_q[b] <= EMPTY;
        end else if (state_q == S_RESP && code_q == FAULT_NONE) begin
            sp_q[bank_q] <= new_sp_q;
        end
    end
endmodule

// File: tb/tb_banked_stack_sequencer.sv
// tb_banked_stack_sequencer: directed stimulus with a queue scoreboard for beats and completions
module tb_banked_stack_sequencer;
    localparam logic [1:0]  NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, LOAD = 2'd3;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [13:0] addr;
        logic        w;
        logic [3:0]  idx;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [0:0]  cmd_bank_i;
    logic [4:0]  cmd_count_i;
    logic [31:0] cmd_load_value_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_write_o;
    logic [13:0] mem_address_o;
    logic [3:0]  beat_index_o;
    logic        done_o;
    logic        fault_o;
    logic [2:0]  fault_code_o;
    logic [0:0]  sp_bank_i;
    logic [31:0] sp_value_o;

    banked_stack_sequencer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_op_i        (cmd_op_i),
        .cmd_bank_i      (cmd_bank_i),
        .cmd_count_i     (cmd_count_i),
        .cmd_load_value_i(cmd_load_value_i),
        .mem_valid_o     (mem_valid_o),
        .mem_ready_i     (mem_ready_i),
        .mem_write_o     (mem_write_o),
        .mem_address_o   (mem_address_o),
        .beat_index_o    (beat_index_o),
        .done_o          (done_o),
        .fault_o         (fault_o),
        .fault_code_o    (fault_code_o),
        .sp_bank_i       (sp_bank_i),
        .sp_value_o      (sp_value_o)
    );

    always #5 clk_i = ~clk_i;

    int    tests = 0, fails = 0, ndone = 0, cyc = 0, acc_cyc = 0, done_cyc = 0;
    beat_t bq[$];
    logic [2:0] rq[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic exp_beats(input logic [13:0] start, input int n, input logic w);
        for (int k = 0; k < n; k++) begin
            bq.push_back('{addr: w ? start - 14'(k) : start + 14'(k), w: w, idx: 4'(k)});
        end
    endtask

    task automatic send(input logic [1:0] op, input logic b, input int n, input logic [31:0] v);
        int k;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_bank_i = b; cmd_count_i = 5'(n); cmd_load_value_i = v;
        for (k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (cmd_ready_o) break;
        end
        if (k == 50) begin tests++; fails++; $display("FAIL accept_timeout: cmd_ready never high"); end
        @(posedge clk_i);
        #1;
        acc_cyc = cyc;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = ndone;
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk_i);
            if (ndone != n0) break;
        end
        if (k == 100) begin tests++; fails++; $display("FAIL done_timeout: no done within 100 cycles"); end
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic b, input int n, input logic [31:0] v, input logic [2:0] code);
        rq.push_back(code);
        send(op, b, n, v);
        wait_done();
    endtask

    task automatic check_sp(input string name, input logic b, input logic [31:0] exp);
        sp_bank_i = b;
        #1;
        chk(name, sp_value_o, exp);
    endtask

    // Monitor: compares every presented beat and every completion against the queues.
    always @(negedge clk_i) begin : mon
        beat_t      e;
        logic [2:0] c;
        if (rst_ni) begin
            if (mem_valid_o) begin
                if (bq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: addr %0d idx %0d, none expected", mem_address_o, beat_index_o);
                end else begin
                    e = mem_ready_i ? bq.pop_front() : bq[0];
                    chk("beat_addr", 32'(mem_address_o), 32'(e.addr));
                    chk("beat_write", 32'(mem_write_o), 32'(e.w));
                    chk("beat_index", 32'(beat_index_o), 32'(e.idx));
                end
            end
            if (done_o) begin
                done_cyc = cyc;
                ndone++;
                chk("ready_low_on_done", 32'(cmd_ready_o), 0);
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: code %0d, none expected", fault_code_o);
                end else begin
                    c = rq.pop_front();
                    chk("fault_code", 32'(fault_code_o), 32'(c));
                    chk("fault", 32'(fault_o), 32'(c != 3'd0));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = NOP; cmd_bank_i = 1'b0; cmd_count_i = '0;
        cmd_load_value_i = '0; mem_ready_i = 1'b1; sp_bank_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 1);
        chk("rst_mem_valid", 32'(mem_valid_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_fault", 32'(fault_o), 0);
        chk("rst_fault_code", 32'(fault_code_o), 0);
        chk("rst_beat_index", 32'(beat_index_o), 0);
        chk("rst_mem_address", 32'(mem_address_o), 0);
        chk("rst_mem_write", 32'(mem_write_o), 0);
        check_sp("rst_sp0", 1'b0, EMPTY);
        check_sp("rst_sp1", 1'b1, EMPTY);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        exp_beats(14'd8191, 1, 1'b1);
        run(PUSH, 1'b1, 1, 0, 3'd0);
        check_sp("push1_sp1", 1'b1, 32'd8191);

        exp_beats(14'd6143, 3, 1'b1);
        run(PUSH, 1'b0, 3, 0, 3'd0);
        chk("push3_latency", 32'(done_cyc - acc_cyc + 1), 32'd5);
        check_sp("push3_sp0", 1'b0, 32'd6141);

        exp_beats(14'd6141, 3, 1'b0);
        run(POP, 1'b0, 3, 0, 3'd0);
        check_sp("pop3_sp0", 1'b0, EMPTY);

        run(LOAD, 1'b0, 0, 32'd4097, 3'd0);
        check_sp("load_sp0", 1'b0, 32'd4097);
        run(PUSH, 1'b0, 2, 0, 3'd1);
        check_sp("overflow_sp0", 1'b0, 32'd4097);
        run(LOAD, 1'b1, 0, 32'd5000, 3'd3);
        check_sp("badload_sp1", 1'b1, 32'd8191);

        exp_beats(14'd8191, 1, 1'b0);
        run(POP, 1'b1, 1, 0, 3'd0);
        check_sp("pop1_sp1", 1'b1, EMPTY);
        run(POP, 1'b1, 1, 0, 3'd2);
        run(PUSH, 1'b0, 0, 0, 3'd4);
        run(PUSH, 1'b0, 17, 0, 3'd4);
        run(NOP, 1'b0, 0, 0, 3'd0);
        run(LOAD, 1'b0, 0, EMPTY, 3'd0);
        check_sp("load_empty_sp0", 1'b0, EMPTY);

        exp_beats(14'd8191, 2, 1'b1);
        rq.push_back(3'd0);
        mem_ready_i = 1'b0;
        send(PUSH, 1'b1, 2, 0);
        for (k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (mem_valid_o) break;
        end
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1 mem_ready_i = 1'b1;
        wait_done();
        check_sp("stall_sp1", 1'b1, 32'd8190);
        chk("queues_drained", 32'(bq.size() + rq.size()), 0);

        exp_beats(14'd6143, 4, 1'b1);
        rq.push_back(3'd0);
        send(PUSH, 1'b0, 4, 0);
        for (k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (mem_valid_o && beat_index_o == 4'd2) break;
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("abort_mem_valid", 32'(mem_valid_o), 0);
        chk("abort_cmd_ready", 32'(cmd_ready_o), 1);
        chk("abort_done", 32'(done_o), 0);
        check_sp("abort_sp0", 1'b0, EMPTY);
        check_sp("abort_sp1", 1'b1, EMPTY);
        bq.delete();
        rq.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        exp_beats(14'd8191, 1, 1'b1);
        run(PUSH, 1'b1, 1, 0, 3'd0);
        check_sp("recover_sp1", 1'b1, 32'd8191);
        chk("final_queues", 32'(bq.size() + rq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
